// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg : shared types and constants for the instruction loader     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_pkg;

  localparam int HDR_LEN = 2;
  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_FIN    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if : byte-stream input and instruction-memory write port |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  import imem_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [INSTR_W-1:0]    wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_word_packer : little-endian byte-to-word assembly               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_word_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic [1:0]         lane_q, lane_d;
  logic [INSTR_W-1:0] asm_q, asm_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear) begin
      lane_d = '0;
      asm_d  = '0;
    end else if (byte_en) begin
      asm_d[{lane_q, 3'b000} +: 8] = byte_data;
      lane_d = lane_q + 2'd1;
    end
  end

  // The completed word is taken from the next-value path so the write
  // port can register it on the same edge that accepts the 4th byte.
  assign word_valid = byte_en && !clear && (lane_q == 2'd3);
  assign word       = asm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : boot-time instruction memory writer with core reset    |
// | hold; trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN.       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader
  import imem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n
);

  localparam logic [16:0]           DEPTH    = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CHECK;
`else
  localparam state_e ST_TAIL = ST_FIN;
`endif

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;

  logic               ready;
  logic               accept;
  logic               start_ok;
  logic               word_valid;
  logic [INSTR_W-1:0] packed_word;
  logic               last_word;
  logic               in_range;
  logic               ck_bad;
  logic               fin_err;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK:                      ready = 1'b1;
`endif
      default:                       ready = 1'b0;
    endcase
  end

  assign accept    = bus.byte_valid && ready;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign last_word = ({1'b0, word_cnt_q} + 17'd1) == {1'b0, len_q};
  assign in_range  = {1'b0, word_cnt_q} < DEPTH;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_en    (accept && (state_q == ST_DATA)),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .word       (packed_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d  = xor_q;
    ck_bad = 1'b0;
    if (start_ok) begin
      xor_d = '0;
    end else if (accept && (state_q != ST_CHECK)) begin
      xor_d = xor_q ^ bus.byte_data;
    end
    if (accept && (state_q == ST_CHECK)) begin
      ck_bad = (bus.byte_data != xor_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xor_q <= '0;
    else        xor_q <= xor_d;
  end
`else
  assign ck_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    fin_err     = 1'b0;

    // Address saturates at the top of memory; overflow words are dropped.
    if (wr_en_q && (wr_addr_q != ADDR_MAX)) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
    if (word_valid && in_range) begin
      wr_en_d   = 1'b1;
      wr_data_d = packed_word;
    end

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start_ok) begin
          state_d     = ST_LEN_LO;
          len_d       = '0;
          word_cnt_d  = '0;
          wr_addr_d   = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_rst_n_d = 1'b0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.byte_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.byte_data;
          state_d     = (len_d == 16'd0) ? ST_TAIL : ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (last_word) state_d = ST_TAIL;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = ST_FIN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
      fin_err     = ({1'b0, len_d} > DEPTH) || ck_bad;
      done_d      = 1'b1;
      err_d       = fin_err;
      cpu_rst_n_d = !fin_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = ready;
  assign done           = done_q;
  assign err            = err_q;
  assign cpu_rst_n      = cpu_rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : randomized loads into a 256-word and a 4-word loader |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_loader;
  import imem_pkg::*;

  localparam int AW_A = 8;
  localparam int AW_B = 2;
  localparam int DEPTH_A = 1 << AW_A;
  localparam int DEPTH_B = 1 << AW_B;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bv    = 1'b0;
  logic [7:0] bd    = 8'd0;

  logic busy_a, done_a, err_a, cpu_a;
  logic busy_b, done_b, err_b, cpu_b;

  imem_loader_if #(.ADDR_WIDTH(AW_A)) bus_a ();
  imem_loader_if #(.ADDR_WIDTH(AW_B)) bus_b ();

  assign bus_a.byte_valid = bv;
  assign bus_a.byte_data  = bd;
  assign bus_b.byte_valid = bv;
  assign bus_b.byte_data  = bd;

  imem_loader #(.XLEN(32), .ADDR_WIDTH(AW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err(err_a), .cpu_rst_n(cpu_a)
  );

  imem_loader #(.XLEN(32), .ADDR_WIDTH(AW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err(err_b), .cpu_rst_n(cpu_b)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  logic [7:0]  pay[$];

  always @(negedge clk) begin
    if (bus_a.wr_en) wq_a.push_back({24'd0, bus_a.wr_addr, bus_a.wr_data});
    if (bus_b.wr_en) wq_b.push_back({30'd0, bus_b.wr_addr, bus_b.wr_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctl_a"}, {bus_a.byte_ready, bus_a.wr_en, busy_a, done_a, err_a, cpu_a}, 64'd0);
    check_eq({tag, "_port_a"}, {bus_a.wr_addr, bus_a.wr_data}, 64'd0);
    check_eq({tag, "_ctl_b"}, {bus_b.byte_ready, bus_b.wr_en, busy_b, done_b, err_b, cpu_b}, 64'd0);
    check_eq({tag, "_port_b"}, {bus_b.wr_addr, bus_b.wr_data}, 64'd0);
  endtask

  // One complete load: n words, optional random payload, optional gappy
  // valid, optional corrupted checksum, optional reset after abort_at payload bytes.
  task automatic load(input int n, input bit rand_pay, input bit gappy,
                      input bit bad_ck, input int abort_at);
    logic [7:0]  q[$];
    logic [7:0]  x;
    logic [31:0] w;
    int          idx;
    int          cyc;
    int          exp_cnt;
    bit          e_a;
    bit          e_b;

    if (rand_pay) begin
      pay.delete();
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom_range(0, 255)));
    end
    q.delete();
    for (int i = 0; i < HDR_LEN; i++) q.push_back(8'(n >> (8 * i)));
    foreach (pay[i]) q.push_back(pay[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(bad_ck ? ~x : x);
`else
    x = 8'd0;
`endif
    wq_a.delete();
    wq_b.delete();

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("started_a", {busy_a, done_a, err_a}, 64'b100);
    check_eq("started_b", {busy_b, done_b, err_b}, 64'b100);

    idx = 0;
    cyc = 0;
    while ((idx < q.size()) && (cyc < 2000)) begin
      if ((abort_at >= 0) && (idx == HDR_LEN + abort_at)) break;
      bd = q[idx];
      bv = gappy ? cyc[0] : 1'b1;
      if (bv && bus_a.byte_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    bv = 1'b0;

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      check_reset_vals("abort");
      @(negedge clk) rst_n = 1'b1;
      return;
    end

    check_eq("bytes_consumed", idx, q.size());

`ifdef IMEM_LOADER_CHECKSUM_EN
    e_a = (n > DEPTH_A) || bad_ck;
    e_b = (n > DEPTH_B) || bad_ck;
`else
    e_a = (n > DEPTH_A);
    e_b = (n > DEPTH_B);
`endif
    // FIN is entered on the edge that accepts the final byte.
    check_eq("fin_a", {done_a, err_a, cpu_a}, {61'd0, 1'b1, e_a, !e_a});
    check_eq("fin_b", {done_b, err_b, cpu_b}, {61'd0, 1'b1, e_b, !e_b});

    @(negedge clk);
    check_eq("idle_busy", {busy_a, busy_b}, 64'd0);
    check_eq("end_addr_a", bus_a.wr_addr, (n > DEPTH_A - 1) ? DEPTH_A - 1 : n);
    check_eq("end_addr_b", bus_b.wr_addr, (n > DEPTH_B - 1) ? DEPTH_B - 1 : n);

    exp_cnt = (n > DEPTH_A) ? DEPTH_A : n;
    check_eq("wr_count_a", wq_a.size(), exp_cnt);
    for (int i = 0; i < exp_cnt && i < wq_a.size(); i++) begin
      w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      check_eq("write_a", wq_a[i], {24'd0, 8'(i), w});
    end
    exp_cnt = (n > DEPTH_B) ? DEPTH_B : n;
    check_eq("wr_count_b", wq_b.size(), exp_cnt);
    for (int i = 0; i < exp_cnt && i < wq_b.size(); i++) begin
      w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      check_eq("write_b", wq_b[i], {30'd0, 2'(i), w});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    pay = {8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    load(2, 1'b0, 1'b0, 1'b0, -1);
    load(0, 1'b1, 1'b0, 1'b0, -1);
    load(3, 1'b1, 1'b1, 1'b0, -1);
    load(5, 1'b1, 1'b0, 1'b0, -1);
    load(2, 1'b1, 1'b0, 1'b0, 6);
    load(1, 1'b1, 1'b0, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    load(1, 1'b1, 1'b0, 1'b0, -1);
    load(1, 1'b1, 1'b0, 1'b1, -1);
`endif
    for (int k = 0; k < 8; k++) begin
      load($urandom_range(0, 9), 1'b1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
